// File: rtl/hdbn_encoder.sv
// HDBn line encoder.
// Converts an NRZ bit stream into bipolar line symbols. In HDBn mode, each run
// of ZMAX+1 zeros is replaced by a B/V or 0/V pattern. In AMI mode, marks simply
// alternate polarity.
// A delay line of L = ZMAX+1 symbol kinds lets the encoder rewrite the oldest zero
// of a window as a B pulse at the moment the window completes.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// r_line[i]    | kind of sample i+1 accepts old (ZERO / MARK / B / V)
// r_zero_cnt   | consecutive zeros accepted since the last mark or V
// r_parity     | odd number of MARK+B pulses since the last V
// r_primed     | accepts since reset, saturating at L (gates out_valid)
// r_last_pos   | polarity of the last non-zero line pulse (1 = positive)
module hdbn_encoder #(
    parameter int ZMAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hdbn_mode,
    input  logic       data_in,
    input  logic       in_valid,
    output logic [1:0] code_out,
    output logic       bp,
    output logic       bn,
    output logic       out_valid,
    output logic       out_viol
);

    localparam int L  = ZMAX + 1;
    localparam int ZW = $clog2(ZMAX + 1);
    localparam int PW = $clog2(L + 1);
    localparam logic [ZW-1:0] ZMAX_C = ZW'(ZMAX);
    localparam logic [PW-1:0] L_C    = PW'(L);

    typedef enum logic [1:0] {
        K_ZERO = 2'd0,
        K_MARK = 2'd1,
        K_B    = 2'd2,
        K_V    = 2'd3
    } kind_t;

    kind_t           r_line [L];
    logic [ZW-1:0]   r_zero_cnt;
    logic            r_parity;
    logic [PW-1:0]   r_primed;
    logic            r_last_pos;
    logic [1:0]      r_code;
    logic            r_viol;
    logic            r_out_valid;

    kind_t           w_line_nxt [L];
    kind_t           w_emit;
    logic            w_sub;
    logic [ZW-1:0]   w_zero_nxt;
    logic            w_parity_nxt;
    logic [1:0]      w_code;
    logic            w_viol;
    logic            w_last_pos_nxt;

    // Input side: classify the new bit, shift the window and insert B/V
    always_comb begin
        w_sub        = hdbn_mode && !data_in && (r_zero_cnt == ZMAX_C);
        w_zero_nxt   = r_zero_cnt;
        w_parity_nxt = r_parity;
        if (data_in) begin
            w_line_nxt[0] = K_MARK;
            w_zero_nxt    = '0;
            w_parity_nxt  = !r_parity;
        end else if (w_sub) begin
            w_line_nxt[0] = K_V;
            w_zero_nxt    = '0;
            // B (if any) and V land on the same edge, so parity restarts at even
            w_parity_nxt  = 1'b0;
        end else begin
            w_line_nxt[0] = K_ZERO;
            if (r_zero_cnt != ZMAX_C) begin
                w_zero_nxt = r_zero_cnt + ZW'(1);
            end
        end
        for (int i = 1; i < L; i++) begin
            w_line_nxt[i] = r_line[i-1];
        end
        // Oldest zero of the window becomes B when the pulse count is even
        if (w_sub && !r_parity) begin
            w_line_nxt[L-1] = K_B;
        end
    end

    // Output side: map the emitted kind to a line polarity
    always_comb begin
        w_emit         = r_line[L-1];
        w_code         = 2'b00;
        w_viol         = 1'b0;
        w_last_pos_nxt = r_last_pos;
        case (w_emit)
            K_MARK, K_B: begin
                w_last_pos_nxt = !r_last_pos;
                w_code         = r_last_pos ? 2'b10 : 2'b01;
            end
            K_V: begin
                w_code = r_last_pos ? 2'b01 : 2'b10;
                w_viol = 1'b1;
            end
            default: begin
                w_code = 2'b00;
            end
        endcase
    end

    // State update on accepted samples; idle cycles hold everything but the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                r_line[i] <= K_ZERO;
            end
            r_zero_cnt  <= '0;
            r_parity    <= 1'b0;
            r_primed    <= '0;
            r_last_pos  <= 1'b0;
            r_code      <= 2'b00;
            r_viol      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < L; i++) begin
                r_line[i] <= w_line_nxt[i];
            end
            r_zero_cnt  <= w_zero_nxt;
            r_parity    <= w_parity_nxt;
            r_last_pos  <= w_last_pos_nxt;
            r_code      <= w_code;
            r_viol      <= w_viol;
            r_out_valid <= (r_primed == L_C);
            if (r_primed != L_C) begin
                r_primed <= r_primed + PW'(1);
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign code_out  = r_code;
    assign bp        = r_code[0];
    assign bn        = r_code[1];
    assign out_valid = r_out_valid;
    assign out_viol  = r_viol;

endmodule

// File: tb/tb_hdbn_encoder.sv
// Testbench for hdbn_encoder: HDB3 instance (ZMAX=3) and ZMAX=2 instance.
module tb_hdbn_encoder;

    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] Z = 2'b00;

    typedef struct packed {
        logic       d;
        logic [1:0] code;
        logic       viol;
    } vec_t;

    typedef struct packed {
        logic [1:0] code;
        logic       viol;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_mode, a_din, a_inv;
    logic [1:0] a_code;
    logic       a_bp, a_bn, a_out_valid, a_viol;
    logic       b_rst, b_mode, b_din, b_inv;
    logic [1:0] b_code;
    logic       b_bp, b_bn, b_out_valid, b_viol;

    hdbn_encoder #(.ZMAX(3)) dut_a (
        .clk(clk), .rst(a_rst), .hdbn_mode(a_mode), .data_in(a_din), .in_valid(a_inv),
        .code_out(a_code), .bp(a_bp), .bn(a_bn), .out_valid(a_out_valid), .out_viol(a_viol)
    );

    hdbn_encoder #(.ZMAX(2)) dut_b (
        .clk(clk), .rst(b_rst), .hdbn_mode(b_mode), .data_in(b_din), .in_valid(b_inv),
        .code_out(b_code), .bp(b_bp), .bn(b_bn), .out_valid(b_out_valid), .out_viol(b_viol)
    );

    int   n_pass = 0;
    int   n_total = 0;
    int   a_nval = 0;
    int   b_nval = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    vec_t t1  [14];
    vec_t t3  [12];
    vec_t t6a [10];
    vec_t t6b [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard for instance A: every strobe pops the oldest expected symbol
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_out_valid === 1'b1) begin
            a_nval++;
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL a_extra_valid: got out_valid=1 expected no symbol pending");
            end else begin
                e = q_a.pop_front();
                check("a_sym", 32'({a_code, a_viol, a_bp, a_bn}),
                      32'({e.code, e.viol, e.code[0], e.code[1]}));
            end
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_out_valid === 1'b1) begin
            b_nval++;
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL b_extra_valid: got out_valid=1 expected no symbol pending");
            end else begin
                e = q_b.pop_front();
                check("b_sym", 32'({b_code, b_viol, b_bp, b_bn}),
                      32'({e.code, e.viol, e.code[0], e.code[1]}));
            end
        end
    end

    task automatic feed_a(input vec_t v, input int gap);
        a_inv = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        a_din = v.d;
        a_inv = 1'b1;
        q_a.push_back('{code: v.code, viol: v.viol});
        @(posedge clk); #1;
        a_inv = 1'b0;
    endtask

    task automatic feed_b(input vec_t v, input int gap);
        b_inv = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        b_din = v.d;
        b_inv = 1'b1;
        q_b.push_back('{code: v.code, viol: v.viol});
        @(posedge clk); #1;
        b_inv = 1'b0;
    endtask

    task automatic reset_a(input logic mode);
        a_rst  = 1'b1;
        a_mode = mode;
        @(posedge clk); #1;
        check("a_rst_out", 32'({a_code, a_bp, a_bn, a_out_valid, a_viol}), 32'd0);
        a_rst = 1'b0;
        q_a.delete();
        a_nval = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        t1 = '{'{1'b1, P, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0},
               '{1'b0, P, 1'b1}, '{1'b0, N, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0},
               '{1'b0, N, 1'b1}, '{1'b1, P, 1'b0}, '{1'b1, N, 1'b0}, '{1'b1, P, 1'b0},
               '{1'b1, N, 1'b0}, '{1'b1, P, 1'b0}};
        t3 = '{'{1'b1, P, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0},
               '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b1, N, 1'b0}, '{1'b1, P, 1'b0},
               '{1'b1, N, 1'b0}, '{1'b1, P, 1'b0}, '{1'b1, N, 1'b0}, '{1'b1, P, 1'b0}};
        t6a = '{'{1'b1, P, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, P, 1'b1},
                '{1'b0, N, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, N, 1'b1}, '{1'b1, P, 1'b0},
                '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0}};
        t6b = '{'{1'b1, P, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, Z, 1'b0}, '{1'b0, P, 1'b1},
                '{1'b1, N, 1'b0}, '{1'b1, P, 1'b0}, '{1'b1, N, 1'b0}};

        a_rst = 1'b1; a_mode = 1'b1; a_din = 1'b0; a_inv = 1'b0;
        b_rst = 1'b1; b_mode = 1'b1; b_din = 1'b0; b_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("a_reset", 32'({a_code, a_bp, a_bn, a_out_valid, a_viol}), 32'd0);
        check("b_reset", 32'({b_code, b_bp, b_bn, b_out_valid, b_viol}), 32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // HDB3 odd then even parity windows, followed by a mark
        for (int i = 0; i < 14; i++) feed_a(t1[i], 0);
        repeat (2) begin @(posedge clk); #1; end
        check("t1_nval", a_nval, 10);
        check("t1_pending", q_a.size(), 4);

        // Plain AMI: no substitutions, long zero run passes through
        reset_a(1'b0);
        for (int i = 0; i < 12; i++) feed_a(t3[i], 0);
        repeat (2) begin @(posedge clk); #1; end
        check("t3_nval", a_nval, 8);
        check("t3_pending", q_a.size(), 4);

        // Same HDB3 stream with random idle gaps
        reset_a(1'b1);
        for (int i = 0; i < 14; i++) feed_a(t1[i], int'($urandom_range(0, 3)));
        repeat (3) begin @(posedge clk); #1; end
        check("t4_nval", a_nval, 10);
        check("t4_pending", q_a.size(), 4);

        // Latency: the first strobe follows the 5th accept, and none earlier
        reset_a(1'b1);
        for (int k = 1; k <= 5; k++) begin
            feed_a(t1[k-1], 2);
            check("lat_valid", 32'(a_out_valid), 32'(k == 5));
        end
        check("lat_code", 32'(a_code), 32'(P));
        @(posedge clk); #1;
        check("lat_drop", 32'(a_out_valid), 32'd0);
        check("lat_hold", 32'(a_code), 32'(P));

        // ZMAX=2 windows, then reset in the middle of a zero run
        for (int i = 0; i < 10; i++) feed_b(t6a[i], 0);
        b_rst = 1'b1;
        @(posedge clk); #1;
        check("t6_nval", b_nval, 7);
        check("t6_rst_out", 32'({b_code, b_bp, b_bn, b_out_valid, b_viol}), 32'd0);
        b_rst = 1'b0;
        q_b.delete();
        b_nval = 0;
        for (int i = 0; i < 7; i++) feed_b(t6b[i], 0);
        repeat (2) begin @(posedge clk); #1; end
        check("t6b_nval", b_nval, 4);
        check("t6b_pending", q_b.size(), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
